// File: rtl/drum_step_sequencer_if.sv
// Control/trigger bundle for drum_step_sequencer.
//   master : control side; drives run, tempo, length, mutes and the pattern write port,
//            receives the trigger pulses and status strobes.
//   slave  : the sequencer itself.
// Signals:
//   run, step_period, last_step, mute          - transport, tempo and voice masking
//   pat_we, pat_voice, pat_step, pat_val       - synchronous pattern write port
//   trigger, step_idx, step_strobe, bar_strobe, playing - sequencer outputs
interface drum_step_sequencer_if #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned STEPS  = 16,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned PER_W  = 16
);
  localparam int unsigned VoiceW = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic              run;
  logic [PER_W-1:0]  step_period;
  logic [STEP_W-1:0] last_step;
  logic [VOICES-1:0] mute;
  logic              pat_we;
  logic [VoiceW-1:0] pat_voice;
  logic [STEP_W-1:0] pat_step;
  logic              pat_val;
  logic [VOICES-1:0] trigger;
  logic [STEP_W-1:0] step_idx;
  logic              step_strobe;
  logic              bar_strobe;
  logic              playing;

  modport master (
    output run, step_period, last_step, mute, pat_we, pat_voice, pat_step, pat_val,
    input  trigger, step_idx, step_strobe, bar_strobe, playing
  );

  modport slave (
    input  run, step_period, last_step, mute, pat_we, pat_voice, pat_step, pat_val,
    output trigger, step_idx, step_strobe, bar_strobe, playing
  );
endinterface

// File: rtl/drum_step_sequencer.sv
// Pattern-driven drum step sequencer. Stores a VOICES x STEPS on/off pattern, advances one
// step every max(step_period,1) audio ticks while running, and emits registered one-tick
// trigger pulses per voice plus step/bar strobes.
// Ports:
//   audio_tick - sample-rate clock, all state on its rising edge
//   reset      - asynchronous, active-high; clears outputs, counter, state and pattern
//   ctrl_io    - slave side of drum_step_sequencer_if (controls, write port, outputs)
module drum_step_sequencer #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned STEPS  = 16,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned PER_W  = 16
) (
  input  logic                  audio_tick,
  input  logic                  reset,
  drum_step_sequencer_if.slave  ctrl_io
);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e            state_q, state_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [VOICES-1:0] trig_q, trig_d;
  logic              step_strobe_q, step_strobe_d;
  logic              bar_strobe_q, bar_strobe_d;
  logic [STEPS-1:0]  pat_q [VOICES];

  logic              fire;
  logic [STEP_W-1:0] fire_step;
  logic [PER_W-1:0]  term_cnt;
  logic [VOICES-1:0] column;

  // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign term_cnt = (ctrl_io.step_period == '0) ? '0 : ctrl_io.step_period - PER_W'(1);

  // State register.
  always_ff @(posedge audio_tick or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ctrl_io.run)  state_d = StPlay;
      StPlay: if (!ctrl_io.run) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Fire decision and output/datapath next values.
  always_comb begin
    fire          = 1'b0;
    fire_step     = '0;
    cnt_d         = cnt_q;
    step_d        = step_q;
    trig_d        = '0;
    step_strobe_d = 1'b0;
    bar_strobe_d  = 1'b0;
    column        = '0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_io.run) begin
          fire      = 1'b1;
          fire_step = '0;
        end
      end
      StPlay: begin
        if (!ctrl_io.run) begin
          // Stop, not pause: the next start begins at step 0.
          step_d = '0;
          cnt_d  = '0;
        end else if (cnt_q == term_cnt) begin
          fire      = 1'b1;
          fire_step = (step_q >= ctrl_io.last_step) ? '0 : step_q + STEP_W'(1);
        end else begin
          // Past a newly shortened terminal count this simply wraps at 2^PER_W.
          cnt_d = cnt_q + PER_W'(1);
        end
      end
      default: ;
    endcase

    for (int v = 0; v < int'(VOICES); v++) begin
      column[v] = pat_q[v][fire_step];
    end

    if (fire) begin
      trig_d        = column & ~ctrl_io.mute;
      step_strobe_d = 1'b1;
      bar_strobe_d  = (fire_step == '0);
      step_d        = fire_step;
      cnt_d         = '0;
    end
  end

  always_ff @(posedge audio_tick or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      step_q        <= '0;
      trig_q        <= '0;
      step_strobe_q <= 1'b0;
      bar_strobe_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      trig_q        <= trig_d;
      step_strobe_q <= step_strobe_d;
      bar_strobe_q  <= bar_strobe_d;
    end
  end

  // Pattern store; a fire at the same edge has already read the old cell (read-before-write).
  always_ff @(posedge audio_tick or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < int'(VOICES); v++) begin
        pat_q[v] <= '0;
      end
    end else if (ctrl_io.pat_we && (int'(ctrl_io.pat_voice) < int'(VOICES))) begin
      pat_q[ctrl_io.pat_voice][ctrl_io.pat_step] <= ctrl_io.pat_val;
    end
  end

  assign ctrl_io.trigger     = trig_q;
  assign ctrl_io.step_idx    = step_q;
  assign ctrl_io.step_strobe = step_strobe_q;
  assign ctrl_io.bar_strobe  = bar_strobe_q;
  assign ctrl_io.playing     = (state_q == StPlay);

endmodule
